// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the opcode-to-format classification
// used by the instruction encoder.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_format(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:                     f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packing of RV32I fields into a 32-bit instruction word.
// Unsupported opcodes yield a NOP and raise the illegal flag.
module instr_field_packer
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        illegal
);

    fmt_e fmt;
    logic is_shift;

    // Branch and jump offsets are always even, so bit 0 never lands in the word.
    logic unused_imm_bit0;
    assign unused_imm_bit0 = imm[0];

    assign fmt      = opcode_format(opcode);
    assign is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    always_comb begin
        instr   = NOP_INSTR;
        illegal = 1'b0;
        case (fmt)
            FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                if (is_shift) begin
                    instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    instr = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: instr = {imm[31:12], rd, opcode};
            FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                instr   = NOP_INSTR;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Accepts RV32I field sets, encodes them, tags each word with a running byte
// address and buffers the result in a small FIFO for instruction-memory writes.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              illegal,
    output logic [7:0]        illegal_cnt
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]       fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              illegal_reg;
    logic [7:0]        illegal_cnt_reg;

    logic [31:0]       packed_instr;
    logic              packed_illegal;
    logic              flush;
    logic              push;
    logic              pop;

    instr_field_packer u_packer (
        .opcode  (opcode),
        .rd      (rd),
        .funct3  (funct3),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct7  (funct7),
        .imm     (imm),
        .instr   (packed_instr),
        .illegal (packed_illegal)
    );

    // A flush wins over any handshake in the same cycle; the offered word is dropped.
    assign flush     = reset || clear;
    assign in_ready  = (count_reg != FULL_CNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // When empty, the head shows zero data and the address the next word will get.
    assign out_instr = out_valid ? fifo_instr[rd_ptr_reg] : 32'h0;
    assign out_addr  = out_valid ? fifo_addr[rd_ptr_reg]  : addr_reg;

    assign illegal     = illegal_reg;
    assign illegal_cnt = illegal_cnt_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_reg] <= packed_instr;
            fifo_addr[wr_ptr_reg]  <= addr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            addr_reg        <= BASE_ADDR;
            illegal_reg     <= 1'b0;
            illegal_cnt_reg <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                addr_reg   <= addr_reg + ADDR_W'(4);
                if (packed_illegal) begin
                    illegal_reg <= 1'b1;
                    if (illegal_cnt_reg != 8'hFF) begin
                        illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
                    end
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a scoreboard queue of expected words and
// addresses is filled on every accepted input and drained on every output pop.
module tb_instr_encoder;

    localparam int          ADDR_W    = 32;
    localparam logic [31:0] BASE_ADDR = 32'h0;
    localparam int          DEPTH     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_word;
    logic [31:0] exp_addr;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                         input logic [31:0] im, input logic [31:0] expw);
        opcode   = op;
        rd       = d;
        funct3   = f3;
        rs1      = s1;
        rs2      = s2;
        funct7   = f7;
        imm      = im;
        exp_word = expw;
        in_valid = 1'b1;
    endtask

    // Called at a falling edge: score the handshakes that the next rising edge will take.
    task automatic step();
        exp_t e;
        if (out_valid && out_ready && !clear) begin
            if (sb.size() == 0) begin
                chk("spurious_pop", 32'(out_valid), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("out_instr", out_instr, e.instr);
                chk("out_addr", out_addr, e.addr);
                $display("pop  instr=0x%08h addr=0x%08h", out_instr, out_addr);
            end
        end
        if (clear) begin
            sb.delete();
            exp_addr = BASE_ADDR;
        end else if (in_valid && in_ready) begin
            e.instr = exp_word;
            e.addr  = exp_addr;
            sb.push_back(e);
            exp_addr = exp_addr + 32'd4;
            $display("push op=0x%02h expect=0x%08h addr=0x%08h", opcode, exp_word, e.addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] head_i;
        logic [31:0] head_a;

        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        rd        = '0;
        funct3    = '0;
        rs1       = '0;
        rs2       = '0;
        funct7    = '0;
        imm       = '0;
        exp_word  = '0;
        exp_addr  = BASE_ADDR;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, BASE_ADDR);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_illegal_cnt", 32'(illegal_cnt), 32'h0);

        // Back-to-back encodes of every format
        out_ready = 1'b1;
        drive(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3);
        step();
        chk("latency_out_valid", 32'(out_valid), 32'h1);
        drive(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd5, 32'h00500093);
        step();
        drive(7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8, 32'h0020A423);
        step();
        drive(7'b1100011, 5'd0, 3'b000, 5'd1, 5'd2, 7'd0, 32'd8, 32'h00208463);
        step();
        drive(7'b0110111, 5'd5, 3'b000, 5'd0, 5'd0, 7'd0, 32'h12345000, 32'h123452B7);
        step();
        drive(7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd16, 32'h010000EF);
        step();
        drive(7'b0010011, 5'd1, 3'b001, 5'd1, 5'd0, 7'd0, 32'd3, 32'h00309093);
        step();
        drive(7'b0010011, 5'd1, 3'b101, 5'd1, 5'd0, 7'b0100000, 32'd3, 32'h4030D093);
        step();

        // Unsupported opcode becomes a NOP and sets the sticky flag
        drive(7'h7F, 5'd1, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h00000013);
        step();
        chk("illegal_set", 32'(illegal), 32'h1);
        chk("illegal_cnt_1", 32'(illegal_cnt), 32'h1);
        drive(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd5, 32'h00500093);
        step();
        chk("illegal_sticky", 32'(illegal), 32'h1);
        chk("illegal_cnt_hold", 32'(illegal_cnt), 32'h1);
        in_valid = 1'b0;
        step();
        step();
        chk("drained_out_valid", 32'(out_valid), 32'h0);

        // Backpressure: fill the FIFO and hold the head
        out_ready = 1'b0;
        drive(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3);
        step();
        chk("fill_in_ready_mid", 32'(in_ready), 32'h1);
        drive(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd5, 32'h00500093);
        step();
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_head_instr", out_instr, 32'h002081B3);
        head_i = out_instr;
        head_a = out_addr;
        drive(7'b0100011, 5'd0, 3'b010, 5'd1, 5'd2, 7'd0, 32'd8, 32'h0020A423);
        step();
        chk("hold_instr", out_instr, head_i);
        chk("hold_addr", out_addr, sb[0].addr);
        chk("hold_addr_stable", out_addr, head_a);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ready_after_pop", 32'(in_ready), 32'h1);
        step();
        step();
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        // Clear mid-stream with two words queued and a word offered
        out_ready = 1'b0;
        drive(7'b0110011, 5'd3, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h002081B3);
        step();
        drive(7'b0010011, 5'd1, 3'b000, 5'd0, 5'd0, 7'd0, 32'd5, 32'h00500093);
        step();
        chk("preclr_out_valid", 32'(out_valid), 32'h1);
        drive(7'h7F, 5'd1, 3'b000, 5'd1, 5'd2, 7'd0, 32'd0, 32'h00000013);
        clear = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'h0);
        chk("clr_illegal", 32'(illegal), 32'h0);
        chk("clr_illegal_cnt", 32'(illegal_cnt), 32'h0);
        chk("clr_out_addr", out_addr, BASE_ADDR);
        out_ready = 1'b1;
        drive(7'b0110111, 5'd5, 3'b000, 5'd0, 5'd0, 7'd0, 32'h12345000, 32'h123452B7);
        step();
        chk("post_clr_addr", out_addr, BASE_ADDR);
        in_valid = 1'b0;
        step();

        // Saturation of the illegal counter
        for (int i = 0; i < 260; i++) begin
            drive(7'h7F, 5'd0, 3'b000, 5'd0, 5'd0, 7'd0, 32'd0, 32'h00000013);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("sat_illegal_cnt", 32'(illegal_cnt), 32'hFF);
        chk("sat_illegal", 32'(illegal), 32'h1);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the instruction field decoder. Accepts RISC-V RV32I fields (opcode, rd, funct3, rs1, rs2, funct7, imm) over a valid/ready handshake and packs them into 32-bit instruction words by opcode format. Output words are tagged with sequential byte addresses and buffered in a small FIFO. Sits between the test/boot program source and instruction-memory write logic.

## Interface
- ADDR_W, 32, width of the address tag
- BASE_ADDR, 0, address of the first word after reset/clear
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  in  1  clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous: empty the FIFO, reload the address to BASE_ADDR, clear errors
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept
- opcode  in  7;  rd  in  5;  funct3  in  3;  rs1  in  5;  rs2  in  5;  funct7  in  7  instruction fields
- imm  in  32  immediate, byte-offset form (bit 0 ignored for B/J)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  encoded word
- out_addr  out  ADDR_W  byte address of the word
- illegal  out  1  sticky: an unsupported opcode was seen
- illegal_cnt  out  8  count of illegal inputs, saturating at 255

## Operation
- Input accept: in_valid && in_ready. Output pop: out_valid && out_ready.
- Format by opcode:
  - R 0110011: {funct7,rs2,rs1,funct3,rd,opcode}
  - I 0010011/0000011/1100111: {imm[11:0],rs1,funct3,rd,opcode}
  - Shift exception: opcode 0010011 with funct3 001/101 uses {funct7,imm[4:0],rs1,funct3,rd,opcode}
  - S 0100011: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B 1100011: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U 0110111/0010111: {imm[31:12],rd,opcode}
  - J 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Any other opcode: enqueue NOP 0x00000013 so the address stream stays contiguous; set illegal; increment illegal_cnt.
- Address counter: tags each accepted word with its current value, then adds 4. Wraps modulo 2^ADDR_W.
- in_ready = !full. Push and pop in the same cycle are allowed whenever the FIFO is non-empty and not full.
- Simultaneous push and pop while full cannot occur because in_ready is low.
- clear has priority over any handshake in the same cycle. A word presented that cycle is dropped and does not advance the address.
- reset has the same effect as clear and has priority over it.

## Timing
- Reset values:
  - out_valid=0
  - in_ready=1
  - out_instr=0
  - out_addr=BASE_ADDR
  - illegal=0
  - illegal_cnt=0
  - FIFO empty
- Latency: accept at edge N gives out_valid at N+1 with the data registered; there is no combinational in→out path.
- Throughput: 1 word/cycle sustained while out_ready=1.
- in_ready depends only on registered state; it never depends on out_ready in the same cycle.
- out_instr and out_addr hold stable while out_valid=1 and out_ready=0.
- illegal and illegal_cnt update at the edge of the accepting cycle.

## Structure
- Shared package riscv_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL)
  - format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD}
  - NOP_INSTR=32'h00000013
- Sub-module instr_field_packer: pure combinational fields→word plus a format/illegal flag. The top level holds the address counter, FIFO, and error state.

## Test plan
- add x3,x1,x2 (R, f3=0, f7=0) then addi x1,x0,5 (imm=5), out_ready=1 → 0x002081B3 @0x0, then 0x00500093 @0x4, on consecutive cycles.
- sw x2,8(x1) → 0x0020A423; beq x1,x2,imm=8 → 0x00208463; lui x5,imm=0x12345000 → 0x123452B7; jal x1,imm=16 → 0x010000EF.
- slli x1,x1,3 (opcode 0010011, f3=001, f7=0, imm=3) → 0x00309093. srai x1,x1,3 (f3=101, f7=0100000) → 0x4030D093.
- opcode 0x7F → out_instr=0x00000013 with the address still incremented; illegal=1 and illegal_cnt=1; illegal stays 1 until clear.
- Hold out_ready=0 and push DEPTH words → in_ready=0 after the DEPTH-th accept and the head stays stable. Release out_ready → words drain in order and in_ready=1 one cycle after the first pop.
- Assert clear mid-stream with the FIFO holding 2 words and in_valid=1 → next cycle out_valid=0, illegal=0, illegal_cnt=0, and the next accepted word is tagged BASE_ADDR.
